// File: rtl/ntm_vector_calculus_controller.sv
// Streams a vector through a shared scalar adder, producing either its first difference
// (differentiation) or its running sum (integration), one result per input element.
module ntm_vector_calculus_controller #(
   parameter int DATA_SIZE    = 64,
   parameter int CONTROL_SIZE = 4
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    START,
   output logic                    READY,
   input  logic [CONTROL_SIZE-1:0] CONTROL,
   input  logic [DATA_SIZE-1:0]    SIZE_IN,
   output logic                    DATA_ENABLE,
   input  logic [DATA_SIZE-1:0]    DATA_IN,
   input  logic                    DATA_IN_ENABLE,
   output logic [DATA_SIZE-1:0]    DATA_OUT,
   output logic                    DATA_OUT_ENABLE,
   output logic                    ADDER_START,
   output logic                    ADDER_OPERATION,
   output logic [DATA_SIZE-1:0]    ADDER_DATA_A,
   output logic [DATA_SIZE-1:0]    ADDER_DATA_B,
   input  logic                    ADDER_READY,
   input  logic [DATA_SIZE-1:0]    ADDER_DATA_OUT
);

   typedef enum logic [1:0] {IDLE, INPUT, ADDER_WAIT, ENDER} state_t;

   state_t               r_state, w_state_next;
   logic                 r_integrate, w_integrate_next;
   logic [DATA_SIZE-1:0] r_size, w_size_next;
   logic [DATA_SIZE-1:0] r_index, w_index_next;
   logic [DATA_SIZE-1:0] r_prev, w_prev_next;
   logic [DATA_SIZE-1:0] r_acc, w_acc_next;
   logic [DATA_SIZE-1:0] r_x, w_x_next;

   logic                 r_ready, w_ready_next;
   logic                 r_data_enable, w_data_enable_next;
   logic [DATA_SIZE-1:0] r_data_out, w_data_out_next;
   logic                 r_data_out_enable, w_data_out_enable_next;
   logic                 r_adder_start, w_adder_start_next;
   logic                 r_adder_op, w_adder_op_next;
   logic [DATA_SIZE-1:0] r_adder_a, w_adder_a_next;
   logic [DATA_SIZE-1:0] r_adder_b, w_adder_b_next;

   // Only CONTROL[0] selects the operation; the remaining bits are reserved.
   generate
      if (CONTROL_SIZE > 1) begin : g_ctrl_spare
         logic w_unused_ctrl;
         assign w_unused_ctrl = ^CONTROL[CONTROL_SIZE-1:1];
      end
   endgenerate

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state           <= IDLE;
         r_integrate       <= 1'b0;
         r_size            <= '0;
         r_index           <= '0;
         r_prev            <= '0;
         r_acc             <= '0;
         r_x               <= '0;
         r_ready           <= 1'b0;
         r_data_enable     <= 1'b0;
         r_data_out        <= '0;
         r_data_out_enable <= 1'b0;
         r_adder_start     <= 1'b0;
         r_adder_op        <= 1'b0;
         r_adder_a         <= '0;
         r_adder_b         <= '0;
      end else begin
         r_state           <= w_state_next;
         r_integrate       <= w_integrate_next;
         r_size            <= w_size_next;
         r_index           <= w_index_next;
         r_prev            <= w_prev_next;
         r_acc             <= w_acc_next;
         r_x               <= w_x_next;
         r_ready           <= w_ready_next;
         r_data_enable     <= w_data_enable_next;
         r_data_out        <= w_data_out_next;
         r_data_out_enable <= w_data_out_enable_next;
         r_adder_start     <= w_adder_start_next;
         r_adder_op        <= w_adder_op_next;
         r_adder_a         <= w_adder_a_next;
         r_adder_b         <= w_adder_b_next;
      end
   end

   always_comb begin
      w_state_next           = r_state;
      w_integrate_next       = r_integrate;
      w_size_next            = r_size;
      w_index_next           = r_index;
      w_prev_next            = r_prev;
      w_acc_next             = r_acc;
      w_x_next               = r_x;
      w_ready_next           = 1'b0;
      w_data_enable_next     = 1'b0;
      w_data_out_next        = r_data_out;
      w_data_out_enable_next = 1'b0;
      w_adder_start_next     = 1'b0;
      // Adder operands persist until the next request so they stay stable while the adder works.
      w_adder_op_next        = r_adder_op;
      w_adder_a_next         = r_adder_a;
      w_adder_b_next         = r_adder_b;

      case (r_state)
         IDLE: begin
            if (START) begin
               if (SIZE_IN != '0) begin
                  w_integrate_next   = CONTROL[0];
                  w_size_next        = SIZE_IN;
                  w_index_next       = '0;
                  w_prev_next        = '0;
                  w_acc_next         = '0;
                  w_data_enable_next = 1'b1;
                  w_state_next       = INPUT;
               end else begin
                  w_ready_next = 1'b1;
               end
            end
         end
         INPUT: begin
            if (DATA_IN_ENABLE) begin
               w_x_next           = DATA_IN;
               w_adder_start_next = 1'b1;
               if (r_integrate) begin
                  w_adder_a_next  = r_acc;
                  w_adder_b_next  = DATA_IN;
                  w_adder_op_next = 1'b0;
               end else begin
                  w_adder_a_next  = DATA_IN;
                  w_adder_b_next  = r_prev;
                  w_adder_op_next = 1'b1;
               end
               w_state_next = ADDER_WAIT;
            end
         end
         ADDER_WAIT: begin
            if (ADDER_READY) begin
               w_data_out_next        = ADDER_DATA_OUT;
               w_data_out_enable_next = 1'b1;
               if (r_integrate) begin
                  w_acc_next = ADDER_DATA_OUT;
               end else begin
                  w_prev_next = r_x;
               end
               w_index_next = r_index + DATA_SIZE'(1);
               if (r_index == r_size - DATA_SIZE'(1)) begin
                  w_state_next = ENDER;
               end else begin
                  w_data_enable_next = 1'b1;
                  w_state_next       = INPUT;
               end
            end
         end
         ENDER: begin
            w_ready_next = 1'b1;
            w_state_next = IDLE;
         end
         default: w_state_next = IDLE;
      endcase
   end

   assign READY           = r_ready;
   assign DATA_ENABLE     = r_data_enable;
   assign DATA_OUT        = r_data_out;
   assign DATA_OUT_ENABLE = r_data_out_enable;
   assign ADDER_START     = r_adder_start;
   assign ADDER_OPERATION = r_adder_op;
   assign ADDER_DATA_A    = r_adder_a;
   assign ADDER_DATA_B    = r_adder_b;

endmodule

// File: tb/tb_ntm_vector_calculus_controller.sv
// Self-checking bench: randomized feeder/adder environment, reference results computed
// directly from the difference/prefix-sum definitions.
module tb_ntm_vector_calculus_controller;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic        START = 1'b0;
   logic        READY;
   logic [3:0]  CONTROL = '0;
   logic [63:0] SIZE_IN = '0;
   logic        DATA_ENABLE;
   logic [63:0] DATA_IN = '0;
   logic        DATA_IN_ENABLE = 1'b0;
   logic [63:0] DATA_OUT;
   logic        DATA_OUT_ENABLE;
   logic        ADDER_START;
   logic        ADDER_OPERATION;
   logic [63:0] ADDER_DATA_A;
   logic [63:0] ADDER_DATA_B;
   logic        ADDER_READY = 1'b0;
   logic [63:0] ADDER_DATA_OUT = '0;

   ntm_vector_calculus_controller #(.DATA_SIZE(64), .CONTROL_SIZE(4)) dut (
      .CLK(CLK), .RST(RST), .START(START), .READY(READY), .CONTROL(CONTROL),
      .SIZE_IN(SIZE_IN), .DATA_ENABLE(DATA_ENABLE), .DATA_IN(DATA_IN),
      .DATA_IN_ENABLE(DATA_IN_ENABLE), .DATA_OUT(DATA_OUT),
      .DATA_OUT_ENABLE(DATA_OUT_ENABLE), .ADDER_START(ADDER_START),
      .ADDER_OPERATION(ADDER_OPERATION), .ADDER_DATA_A(ADDER_DATA_A),
      .ADDER_DATA_B(ADDER_DATA_B), .ADDER_READY(ADDER_READY),
      .ADDER_DATA_OUT(ADDER_DATA_OUT)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int failures = 0;

   logic [63:0] xs[$];
   logic [63:0] exp_q[$];
   logic [63:0] got[$];
   int n_de, n_as, n_doe, n_rdy, rdy_cyc, last_doe_cyc;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic compute_expected(input bit integrate);
      logic [63:0] sum;
      logic [63:0] prev;
      sum = '0;
      prev = '0;
      exp_q.delete();
      foreach (xs[i]) begin
         if (integrate) begin
            sum = sum + xs[i];
            exp_q.push_back(sum);
         end else begin
            exp_q.push_back(xs[i] - prev);
            prev = xs[i];
         end
      end
   endtask

   task automatic check_outputs_zero(input string tag);
      chk({tag, "_ready"}, {63'd0, READY}, 64'd0);
      chk({tag, "_de"}, {63'd0, DATA_ENABLE}, 64'd0);
      chk({tag, "_doe"}, {63'd0, DATA_OUT_ENABLE}, 64'd0);
      chk({tag, "_dout"}, DATA_OUT, 64'd0);
      chk({tag, "_as"}, {63'd0, ADDER_START}, 64'd0);
      chk({tag, "_aop"}, {63'd0, ADDER_OPERATION}, 64'd0);
      chk({tag, "_aa"}, ADDER_DATA_A, 64'd0);
      chk({tag, "_ab"}, ADDER_DATA_B, 64'd0);
   endtask

   // Runs one operation over xs with a randomly slow feeder and adder; optional
   // disturbance (spurious START/ADDER_READY) or a reset injected in ADDER_WAIT.
   task automatic run_op(input string tag, input bit integrate, input bit disturb,
                         input bit do_reset);
      int cyc, k, feed_cnt, add_cnt, trail;
      bit feed_pend, add_pend, just_started, rdy_seen, aborted;
      logic [63:0] la, lb;
      logic lop;
      int n;
      n = xs.size();
      compute_expected(integrate);
      got.delete();
      n_de = 0; n_as = 0; n_doe = 0; n_rdy = 0; rdy_cyc = -1; last_doe_cyc = -1;
      k = 0; feed_cnt = 0; add_cnt = 0; trail = 0;
      feed_pend = 0; add_pend = 0; rdy_seen = 0; aborted = 0;
      la = '0; lb = '0; lop = 1'b0;
      @(negedge CLK);
      START = 1'b1;
      CONTROL = {3'($urandom), integrate};
      SIZE_IN = 64'(n);
      cyc = 0;
      while (1) begin
         @(negedge CLK);
         cyc++;
         just_started = 0;
         if (READY) begin n_rdy++; rdy_cyc = cyc; rdy_seen = 1; end
         if (DATA_OUT_ENABLE) begin got.push_back(DATA_OUT); n_doe++; last_doe_cyc = cyc; end
         if (DATA_ENABLE) begin n_de++; feed_pend = 1; feed_cnt = $urandom_range(0, 3); end
         if (add_pend) begin
            chk({tag, "_hold_a"}, ADDER_DATA_A, la);
            chk({tag, "_hold_b"}, ADDER_DATA_B, lb);
            chk({tag, "_hold_op"}, {63'd0, ADDER_OPERATION}, {63'd0, lop});
         end
         if (ADDER_START) begin
            n_as++; add_pend = 1; just_started = 1; add_cnt = $urandom_range(1, 3);
            la = ADDER_DATA_A; lb = ADDER_DATA_B; lop = ADDER_OPERATION;
         end
         if (do_reset && add_pend) begin
            RST = 1'b0;
            #1;
            check_outputs_zero({tag, "_inrst"});
            START = 1'b1; ADDER_READY = 1'b1; DATA_IN_ENABLE = 1'b1;
            repeat (3) begin
               @(negedge CLK);
               check_outputs_zero({tag, "_hold"});
            end
            @(negedge CLK);
            START = 1'b0; ADDER_READY = 1'b0; DATA_IN_ENABLE = 1'b0;
            RST = 1'b1;
            aborted = 1;
            break;
         end
         DATA_IN_ENABLE = 1'b0;
         ADDER_READY = 1'b0;
         START = 1'b0;
         if (feed_pend) begin
            if (feed_cnt == 0) begin
               feed_pend = 0;
               if (k < n) begin
                  DATA_IN_ENABLE = 1'b1;
                  DATA_IN = xs[k];
                  k++;
               end
            end else begin
               feed_cnt--;
            end
         end
         if (add_pend && !just_started) begin
            add_cnt--;
            if (add_cnt == 0) begin
               ADDER_READY = 1'b1;
               ADDER_DATA_OUT = lop ? (la - lb) : (la + lb);
               add_pend = 0;
            end
         end else if (disturb && !add_pend && $urandom_range(0, 2) == 0) begin
            ADDER_READY = 1'b1;
            ADDER_DATA_OUT = {$urandom, $urandom};
         end
         if (disturb && !rdy_seen && n > 0 && $urandom_range(0, 2) == 0) begin
            START = 1'b1;
            SIZE_IN = 64'($urandom_range(0, 5));
            CONTROL = 4'($urandom);
         end
         if (rdy_seen) begin
            trail++;
            if (trail > 3) break;
         end
         if (cyc > 2000) begin
            chk({tag, "_timeout"}, 64'(cyc), 64'd0);
            break;
         end
      end
      START = 1'b0; DATA_IN_ENABLE = 1'b0; ADDER_READY = 1'b0;
      if (aborted) begin
         chk({tag, "_abort_ready"}, 64'(n_rdy), 64'd0);
      end else begin
         chk({tag, "_n_out"}, 64'(got.size()), 64'(n));
         for (int i = 0; i < n && i < got.size(); i++)
            chk($sformatf("%s_out%0d", tag, i), got[i], exp_q[i]);
         chk({tag, "_n_de"}, 64'(n_de), 64'(n));
         chk({tag, "_n_as"}, 64'(n_as), 64'(n));
         chk({tag, "_n_doe"}, 64'(n_doe), 64'(n));
         chk({tag, "_n_ready"}, 64'(n_rdy), 64'd1);
         if (n > 0) chk({tag, "_ready_cyc"}, 64'(rdy_cyc), 64'(last_doe_cyc + 1));
         else chk({tag, "_ready_cyc"}, 64'(rdy_cyc), 64'd1);
      end
      $display("op %s integrate=%0d n=%0d outs=%0d ready=%0d", tag, integrate, n, got.size(), n_rdy);
   endtask

   initial begin
      repeat (2) @(negedge CLK);
      check_outputs_zero("reset");
      @(negedge CLK);
      RST = 1'b1;

      xs = '{64'd5, 64'd8, 64'd2};
      run_op("diff3", 1'b0, 1'b0, 1'b0);
      chk("diff3_c0", got[0], 64'd5);
      chk("diff3_c1", got[1], 64'd3);
      chk("diff3_c2", got[2], -64'sd6);

      xs = '{64'd1, 64'd2, 64'd3, 64'd4};
      run_op("int4", 1'b1, 1'b0, 1'b0);
      chk("int4_c3", got[3], 64'd10);

      xs.delete();
      run_op("size0", 1'b1, 1'b0, 1'b0);

      xs = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1};
      run_op("wrap", 1'b1, 1'b0, 1'b0);
      chk("wrap_c1", got[1], 64'h8000_0000_0000_0000);

      xs = '{64'd9, 64'd4, 64'd100, 64'd3, 64'd3};
      run_op("calm", 1'b0, 1'b0, 1'b0);
      run_op("dist", 1'b0, 1'b1, 1'b0);
      run_op("dist_i", 1'b1, 1'b1, 1'b0);

      xs = '{64'd11, 64'd22, 64'd33};
      run_op("rst", 1'b1, 1'b0, 1'b1);
      xs = '{64'd7};
      run_op("after_rst", 1'b1, 1'b0, 1'b0);
      chk("after_rst_c0", got[0], 64'd7);

      for (int r = 0; r < 6; r++) begin
         int n;
         n = $urandom_range(1, 8);
         xs.delete();
         for (int i = 0; i < n; i++) xs.push_back({$urandom, $urandom});
         run_op($sformatf("rand%0d", r), 1'($urandom), 1'($urandom), 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
